// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: opcode constants, registered decode record and immediate helper
package tinyriscv_pkg;
  localparam int XW = 32;
  localparam logic [6:0] OP_IMM = 7'h13, OP = 7'h33, LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63;
  localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;
  localparam logic [6:0] FENCE = 7'h0f, SYSTEM = 7'h73, CUSTOM0 = 7'h0b;
  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20, F7_MUL = 7'h01;
  typedef struct packed {
    logic [XW-1:0] op1;
    logic [XW-1:0] op2;
    logic [31:0]   inst;
    logic [XW-1:0] inst_addr;
    logic          reg_we;
    logic [4:0]    reg_waddr;
    logic          csr_we;
    logic [11:0]   csr_waddr;
    logic [XW-1:0] csr_rdata;
    logic [XW-1:0] store_data;
    logic [2:0]    compare;
    logic          illegal;
  } decode_t;
  function automatic logic [XW-1:0] imm_sext(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    return o == STORE ? XW'($signed({i[31:25], i[11:7]})) :
           o == BRANCH ? XW'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})) :
           o == JAL ? XW'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})) :
           (o == LUI || o == AUIPC) ? XW'($signed({i[31:12], 12'b0})) :
           XW'($signed(i[31:20]));
  endfunction
endpackage

// File: rtl/id_decode.sv
// id_decode: combinational instruction word to decode record plus source-register usage
module id_decode import tinyriscv_pkg::*; #(
  parameter int XLEN = XW,
  parameter bit EN_M = 1'b1,
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] csr_rdata,
  output decode_t         d,
  output logic            uses_rs1,
  output logic            uses_rs2
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm, cb;
  logic is_i, is_r, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys, is_csr, is_cust;
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign imm = imm_sext(inst);
  assign is_i = opc == OP_IMM && (f3 == 3'd1 ? f7 == F7_BASE : f3 == 3'd5 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1);
  assign is_r = opc == OP && (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == F7_MUL && EN_M));
  assign is_l = opc == LOAD && f3 != 3'd3 && f3[2:1] != 2'b11;
  assign is_s = opc == STORE && f3 < 3'd3;
  assign is_b = opc == BRANCH && f3[2:1] != 2'b01;
  assign is_jal = opc == JAL;
  assign is_jalr = opc == JALR && f3 == 3'd0;
  assign is_lui = opc == LUI;
  assign is_auipc = opc == AUIPC;
  assign is_fence = opc == FENCE && f3[2:1] == 2'b00;
  assign is_sys = EN_CSR && opc == SYSTEM && f3 != 3'd4;
  assign is_csr = is_sys && f3 != 3'd0;
  assign is_cust = opc == CUSTOM0;
  assign uses_rs1 = is_i | is_r | is_l | is_s | is_b | is_jalr | is_cust | (is_csr & ~f3[2]);
  assign uses_rs2 = is_r | is_s | is_b | is_cust;
  // SLTI/SLTIU compare against the immediate; everything else against rs2
  assign cb = (opc == OP_IMM && f3[2:1] == 2'b01) ? imm : r2;
  always_comb begin
    d = '0;
    d.inst = inst;
    d.inst_addr = inst_addr;
    d.illegal = ~(is_i | is_r | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc | is_fence | is_sys | is_cust);
    d.reg_we = is_i | is_r | is_l | is_jal | is_jalr | is_lui | is_auipc | is_cust | is_csr;
    d.reg_waddr = d.reg_we ? inst[11:7] : 5'd0;
    d.csr_we = is_csr;
    d.csr_waddr = is_csr ? inst[31:20] : 12'd0;
    d.csr_rdata = is_csr ? csr_rdata : '0;
    d.store_data = is_s ? r2 : '0;
    d.op1 = (is_jal | is_auipc | is_b) ? inst_addr : is_lui ? imm :
            (is_csr & f3[2]) ? XLEN'(inst[19:15]) : uses_rs1 ? r1 : '0;
    d.op2 = (is_r | is_cust) ? r2 : (is_i | is_l | is_s | is_b | is_jal | is_jalr | is_auipc) ? imm : '0;
    d.compare = {$signed(r1) >= $signed(cb), r1 >= cb, r1 == cb};
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered decode stage with handshakes, load-use interlock, flush and stall counter
module id_stage_pipe import tinyriscv_pkg::*; #(
  parameter int XLEN = XW,
  parameter bit EN_M = 1'b1,
  parameter bit EN_CSR = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  output logic [4:0]       reg1_raddr_o,
  output logic [4:0]       reg2_raddr_o,
  input  logic [XLEN-1:0]  reg1_rdata_i,
  input  logic [XLEN-1:0]  reg2_rdata_i,
  output logic [11:0]      csr_raddr_o,
  input  logic [XLEN-1:0]  csr_rdata_i,
  input  logic             flush_i,
  input  logic             ex_load_pend_i,
  input  logic [4:0]       ex_load_rd_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  inst_addr_o,
  output logic             reg_we_o,
  output logic [4:0]       reg_waddr_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [XLEN-1:0]  csr_rdata_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [2:0]       compare_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  decode_t dec, q;
  logic u1, u2, haz, adv, take;
  id_decode #(.XLEN(XLEN), .EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
    .inst(inst_i), .inst_addr(inst_addr_i), .r1(reg1_rdata_i), .r2(reg2_rdata_i),
    .csr_rdata(csr_rdata_i), .d(dec), .uses_rs1(u1), .uses_rs2(u2)
  );
  assign reg1_raddr_o = inst_i[19:15];
  assign reg2_raddr_o = inst_i[24:20];
  assign csr_raddr_o = inst_i[31:20];
  assign haz = if_valid_i & ex_load_pend_i & |ex_load_rd_i &
               ((u1 & inst_i[19:15] == ex_load_rd_i) | (u2 & inst_i[24:20] == ex_load_rd_i));
  assign adv = ~ex_valid_o | ex_ready_i;
  assign take = if_valid_i & ~haz & ~flush_i;
  // a flushed beat is drained so fetch never waits on a dead instruction
  assign if_ready_o = flush_i | (adv & ~haz);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      ex_valid_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (flush_i | adv) begin
        q <= take ? dec : '0;
        ex_valid_o <= take;
      end
      if (adv & haz & ~flush_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
  assign op1_o = q.op1;
  assign op2_o = q.op2;
  assign inst_o = q.inst;
  assign inst_addr_o = q.inst_addr;
  assign reg_we_o = q.reg_we;
  assign reg_waddr_o = q.reg_waddr;
  assign csr_we_o = q.csr_we;
  assign csr_waddr_o = q.csr_waddr;
  assign csr_rdata_o = q.csr_rdata;
  assign store_data_o = q.store_data;
  assign compare_o = q.compare;
  assign illegal_o = q.illegal;
endmodule
